operand_result_checker: RTL and testbench

//  Synthesizable receiving end of the operand-stimulus interface used on datapath blocks.
//  A stimulus source offers (a, b, expected) over a valid/ready handshake.
//  The checker drives a/b into the DUT, waits a settle window, samples the DUT result and compares it.
//  It keeps pass/fail counts, so datapath self-test runs on board with no simulator.

---
 rtl/chk_pkg.sv | 15 +
 rtl/sat_counter.sv | 31 +++
 rtl/operand_result_checker.sv | 165 ++++++++++++++++
 tb/tb_operand_result_checker.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// chk_pkg
//   Shared definitions for operand_result_checker and its sub-modules:
//   FSM state type and default widths.
package chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 9;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter; sticks at all-ones instead of wrapping.
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   inc    in   increment request (ignored once saturated)
//   clr    in   synchronous clear, has priority over inc
//   count  out  current count
module sat_counter
  import chk_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/operand_result_checker.sv
// operand_result_checker
//   Receiving end of the operand-stimulus interface. Accepts (a, b, expected)
//   over valid/ready, drives a/b into a datapath DUT, waits SETTLE_CYCLES
//   clocks, then compares the DUT result with the expected value and keeps
//   saturating pass/fail counts plus a sticky fail flag.
// Optional feature macro: FAIL_CAPTURE_EN
//   When defined, adds fail_a/fail_b/fail_exp/fail_got holding the operands,
//   expected value and DUT result of the first mismatch since reset/clear.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous clear of counters, sticky flag, capture
//   in_valid/in_ready   stimulus handshake
//   in_a, in_b, in_exp  operands and expected result
//   dut_a, dut_b        registered operands driven to the DUT
//   dut_c               DUT result
//   chk_pulse, chk_fail comparison strobe and mismatch flag
//   pass_cnt, fail_cnt  saturating match / mismatch counts
//   any_fail            sticky mismatch flag
//   fail_a/b/exp/got    first-mismatch capture (FAIL_CAPTURE_EN only)
module operand_result_checker
  import chk_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_exp,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  input  logic [DATA_W-1:0] dut_c,
  output logic              chk_pulse,
  output logic              chk_fail,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              any_fail
`ifdef FAIL_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] fail_a,
  output logic [DATA_W-1:0] fail_b,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
`endif
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q;
  logic [DATA_W-1:0]  exp_q;
  logic               accept;
  logic               mismatch;

  assign mismatch = (dut_c != exp_q);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    chk_pulse = 1'b0;
    chk_fail  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        chk_pulse = 1'b1;
        chk_fail  = mismatch;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_a    <= '0;
      dut_b    <= '0;
      exp_q    <= '0;
      settle_q <= '0;
    end else if (accept) begin
      dut_a    <= in_a;
      dut_b    <= in_b;
      exp_q    <= in_exp;
      settle_q <= SETTLE_INIT;
    end else if ((state_q == SETTLE) && (settle_q != '0)) begin
      settle_q <= settle_q - SET_W'(1);
    end
  end

  // clear has priority, so a clear landing on the COMPARE cycle discards
  // that comparison's effect on the flag (the strobe itself still fires).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_fail <= 1'b0;
    end else if (clear) begin
      any_fail <= 1'b0;
    end else if (chk_fail) begin
      any_fail <= 1'b1;
    end
  end

`ifdef FAIL_CAPTURE_EN
  // any_fail doubles as "capture already taken" since both share reset/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_a   <= '0;
      fail_b   <= '0;
      fail_exp <= '0;
      fail_got <= '0;
    end else if (clear) begin
      fail_a   <= '0;
      fail_b   <= '0;
      fail_exp <= '0;
      fail_got <= '0;
    end else if (chk_fail && !any_fail) begin
      fail_a   <= dut_a;
      fail_b   <= dut_b;
      fail_exp <= exp_q;
      fail_got <= dut_c;
    end
  end
`endif

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (chk_pulse && !mismatch),
    .clr   (clear),
    .count (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (chk_fail),
    .clr   (clear),
    .count (fail_cnt)
  );

endmodule

// File: tb/tb_operand_result_checker.sv
module tb_operand_result_checker;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_a = '0, in_b = '0, in_exp = '0;
  logic [8:0]  dut_a, dut_b, dut_c;
  logic        chk_pulse, chk_fail, any_fail;
  logic [15:0] pass_cnt, fail_cnt;
`ifdef FAIL_CAPTURE_EN
  logic [8:0]  fail_a, fail_b, fail_exp, fail_got;
`endif

  // second instance with 2-bit counters for the saturation scenario
  logic        clear2 = 1'b0;
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [8:0]  in_a2 = '0, in_b2 = '0, in_exp2 = '0;
  logic [8:0]  dut_a2, dut_b2, dut_c2;
  logic        chk_pulse2, chk_fail2, any_fail2;
  logic [1:0]  pass_cnt2, fail_cnt2;
`ifdef FAIL_CAPTURE_EN
  logic [8:0]  fail_a2, fail_b2, fail_exp2, fail_got2;
`endif

  // DUT under test is an adder
  assign dut_c  = dut_a + dut_b;
  assign dut_c2 = dut_a2 + dut_b2;

  always #5 clk = ~clk;

  operand_result_checker #(.DATA_W(9), .CNT_W(16), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_exp(in_exp), .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
    .chk_pulse(chk_pulse), .chk_fail(chk_fail), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .any_fail(any_fail)
`ifdef FAIL_CAPTURE_EN
    , .fail_a(fail_a), .fail_b(fail_b), .fail_exp(fail_exp), .fail_got(fail_got)
`endif
  );

  operand_result_checker #(.DATA_W(9), .CNT_W(2), .SETTLE_CYCLES(SETTLE)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_exp(in_exp2), .dut_a(dut_a2), .dut_b(dut_b2), .dut_c(dut_c2),
    .chk_pulse(chk_pulse2), .chk_fail(chk_fail2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
    .any_fail(any_fail2)
`ifdef FAIL_CAPTURE_EN
    , .fail_a(fail_a2), .fail_b(fail_b2), .fail_exp(fail_exp2), .fail_got(fail_got2)
`endif
  );

  int checks = 0;
  int failures = 0;

  // reference model: result = (a+b) mod 512, compared against expected
  int         m_pass, m_fail;
  bit         m_any;
  logic [8:0] m_fa, m_fb, m_fe, m_fg;

  function automatic bit model_mismatch(input logic [8:0] a, input logic [8:0] b,
                                        input logic [8:0] e);
    int sum;
    sum = (int'(a) + int'(b)) % 512;
    return sum != int'(e);
  endfunction

  task automatic model_reset();
    m_pass = 0; m_fail = 0; m_any = 0;
    m_fa = '0; m_fb = '0; m_fe = '0; m_fg = '0;
  endtask

  task automatic model_apply(input logic [8:0] a, input logic [8:0] b, input logic [8:0] e);
    if (model_mismatch(a, b, e)) begin
      if (!m_any) begin
        m_fa = a; m_fb = b; m_fe = e; m_fg = 9'((int'(a) + int'(b)) % 512);
      end
      m_fail++;
      m_any = 1;
    end else begin
      m_pass++;
    end
  endtask

  // Offer one vector, wait for acceptance and then for the check strobe.
  task automatic send(input logic [8:0] a, input logic [8:0] b, input logic [8:0] e,
                      output bit seen, output bit fl, output int lat);
    bit acc;
    seen = 0; fl = 0; lat = 0; acc = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout got=no_accept want=accept");
      return;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (dut_a !== a || dut_b !== b || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL drive_operands got a=%0d b=%0d rdy=%b want a=%0d b=%0d rdy=0",
                   dut_a, dut_b, in_ready, a, b);
        end
      end
      if (chk_pulse) begin seen = 1; fl = chk_fail; lat = i; break; end
    end
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (pass_cnt !== 16'(m_pass) || fail_cnt !== 16'(m_fail) || any_fail !== m_any) begin
      failures++;
      $display("FAIL %s got pass=%0d fail=%0d any=%b want pass=%0d fail=%0d any=%b",
               tag, pass_cnt, fail_cnt, any_fail, m_pass, m_fail, m_any);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || dut_a !== 9'd0 || dut_b !== 9'd0 || chk_pulse !== 1'b0 ||
        pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || any_fail !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got rdy=%b a=%0d b=%0d pulse=%b pass=%0d fail=%0d any=%b want 1 0 0 0 0 0 0",
               in_ready, dut_a, dut_b, chk_pulse, pass_cnt, fail_cnt, any_fail);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || chk_pulse !== 1'b0 || dut_a !== 9'd0 || pass_cnt !== 16'd0) begin
        failures++;
        $display("FAIL idle_cycle%0d got rdy=%b pulse=%b a=%0d pass=%0d want 1 0 0 0",
                 i, in_ready, chk_pulse, dut_a, pass_cnt);
      end
    end
  endtask

  task automatic test_match();
    bit seen, fl; int lat;
    send(9'd45, 9'd3, 9'd48, seen, fl, lat);
    model_apply(9'd45, 9'd3, 9'd48);
    checks++;
    if (!seen || lat != SETTLE + 1 || fl !== 1'b0) begin
      failures++;
      $display("FAIL match_pulse got seen=%b lat=%0d fail=%b want seen=1 lat=%0d fail=0",
               seen, lat, fl, SETTLE + 1);
    end
    @(negedge clk);
    check_counts("match_counts");
    checks++;
    if (dut_a !== 9'd45) begin
      failures++;
      $display("FAIL dut_a_hold got=%0d want=45", dut_a);
    end
  endtask

  task automatic test_mismatch();
    bit seen, fl; int lat;
    send(9'd99, 9'd77, 9'd0, seen, fl, lat);
    model_apply(9'd99, 9'd77, 9'd0);
    checks++;
    if (!seen || fl !== 1'b1) begin
      failures++;
      $display("FAIL mismatch_pulse got seen=%b fail=%b want seen=1 fail=1", seen, fl);
    end
    @(negedge clk);
    check_counts("mismatch_counts");
    send(9'd10, 9'd20, 9'd5, seen, fl, lat);
    model_apply(9'd10, 9'd20, 9'd5);
    @(negedge clk);
    check_counts("mismatch2_counts");
`ifdef FAIL_CAPTURE_EN
    checks++;
    if (fail_a !== m_fa || fail_b !== m_fb || fail_exp !== m_fe || fail_got !== m_fg) begin
      failures++;
      $display("FAIL capture got a=%0d b=%0d e=%0d c=%0d want a=%0d b=%0d e=%0d c=%0d",
               fail_a, fail_b, fail_exp, fail_got, m_fa, m_fb, m_fe, m_fg);
    end
`endif
  endtask

  task automatic test_random();
    bit seen, fl, want; int lat;
    logic [8:0] a, b, e;
    for (int n = 0; n < 30; n++) begin
      a = 9'($urandom_range(0, 511));
      b = 9'($urandom_range(0, 511));
      e = ($urandom_range(0, 1) == 1) ? 9'((int'(a) + int'(b)) % 512) : 9'($urandom_range(0, 511));
      want = model_mismatch(a, b, e);
      send(a, b, e, seen, fl, lat);
      model_apply(a, b, e);
      checks++;
      if (!seen || fl !== want || lat != SETTLE + 1) begin
        failures++;
        $display("FAIL random%0d got seen=%b fail=%b lat=%0d want seen=1 fail=%b lat=%0d",
                 n, seen, fl, lat, want, SETTLE + 1);
      end
    end
    @(negedge clk);
    check_counts("random_counts");
  endtask

  task automatic test_back_to_back();
    logic [8:0] va[3], vb[3], ve[3];
    bit         vf[3];
    int idx, acc, pulses, last;
    bit accept_now, prev_acc;
    va = '{9'd1, 9'd200, 9'd300}; vb = '{9'd2, 9'd100, 9'd300}; ve = '{9'd3, 9'd7, 9'd88};
    for (int i = 0; i < 3; i++) vf[i] = model_mismatch(va[i], vb[i], ve[i]);
    idx = 0; acc = 0; pulses = 0; last = -1; prev_acc = 0;
    @(posedge clk); #1;
    in_a = va[0]; in_b = vb[0]; in_exp = ve[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (prev_acc) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready_low cyc=%0d got=%b want=0", cyc, in_ready);
        end
      end
      if (chk_pulse) begin
        checks++;
        if (pulses >= 3 || chk_fail !== vf[pulses < 3 ? pulses : 0] ||
            (pulses > 0 && cyc - last != SETTLE + 2)) begin
          failures++;
          $display("FAIL b2b_pulse%0d got fail=%b gap=%0d want fail=%b gap=%0d",
                   pulses, chk_fail, cyc - last, vf[pulses < 3 ? pulses : 0], SETTLE + 2);
        end
        pulses++;
        last = cyc;
      end
      accept_now = in_ready && in_valid;
      @(posedge clk); #1;
      prev_acc = accept_now;
      if (accept_now) begin
        model_apply(va[idx], vb[idx], ve[idx]);
        acc++;
        idx++;
        if (idx < 3) begin
          in_a = va[idx]; in_b = vb[idx]; in_exp = ve[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (acc != 3 || pulses != 3) begin
      failures++;
      $display("FAIL b2b_totals got accepts=%0d pulses=%0d want 3 3", acc, pulses);
    end
    check_counts("b2b_counts");
  endtask

  task automatic test_clear_compare();
    bit seen, fl; int lat;
    send(9'd5, 9'd6, 9'd11, seen, fl, lat);
    // now sitting at the negedge inside the COMPARE cycle
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL clear_compare_pulse got=0 want=1");
    end
    @(negedge clk);
    check_counts("clear_compare_counts");
`ifdef FAIL_CAPTURE_EN
    checks++;
    if (fail_a !== 9'd0 || fail_got !== 9'd0) begin
      failures++;
      $display("FAIL clear_capture got a=%0d c=%0d want 0 0", fail_a, fail_got);
    end
`endif
  endtask

  task automatic test_reset_settle();
    bit acc;
    int pulses;
    acc = 0; pulses = 0;
    @(posedge clk); #1;
    in_a = 9'd17; in_b = 9'd4; in_exp = 9'd21; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (!acc || in_ready !== 1'b1 || dut_a !== 9'd0 || dut_b !== 9'd0) begin
      failures++;
      $display("FAIL reset_settle got acc=%b rdy=%b a=%0d b=%0d want 1 1 0 0",
               acc, in_ready, dut_a, dut_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (chk_pulse) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_drop_pulses got=%0d want=0", pulses);
    end
    check_counts("reset_settle_counts");
  endtask

  task automatic test_saturation();
    int pulses, accepts;
    bit acc;
    pulses = 0; accepts = 0;
    for (int n = 0; n < 5; n++) begin
      acc = 0;
      @(posedge clk); #1;
      in_a2 = 9'(n * 11); in_b2 = 9'(n + 1); in_exp2 = 9'(n * 11 + n + 1); in_valid2 = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (in_ready2) begin acc = 1; break; end
      end
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      if (acc) accepts++;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (chk_pulse2) begin pulses++; break; end
      end
    end
    @(negedge clk);
    checks++;
    if (pass_cnt2 !== 2'd3 || fail_cnt2 !== 2'd0 || pulses != 5 || accepts != 5) begin
      failures++;
      $display("FAIL saturation got pass=%0d fail=%0d pulses=%0d accepts=%0d want 3 0 5 5",
               pass_cnt2, fail_cnt2, pulses, accepts);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_match();
    test_mismatch();
    test_random();
    test_back_to_back();
    test_clear_compare();
    test_reset_settle();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
